// File: rtl/membuf_pkg.sv
// membuf_pkg: shared widths, request layout, FSM states and lane helpers for membuf
package membuf_pkg;
  localparam int XLEN = 32;
  localparam int MEMB_PARA = 9;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  // Field order matches {mem_para, mem_addr, mem_wdata} so a push is a plain concatenation
  typedef struct packed {
    logic [4:0]      rd;
    logic [2:0]      f3;
    logic            st;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;
  // Legal funct3 for the direction and naturally aligned for its size
  function automatic logic legal(input logic st, input logic [2:0] f3, input logic [1:0] off);
    logic ok_f3;
    ok_f3 = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
    return ok_f3 && !(f3[1:0] == SZ_H && off[0]) && !(f3[1:0] == SZ_W && off != 2'b00);
  endfunction
  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] off);
    return (sz == SZ_B ? 4'b0001 : sz == SZ_H ? 4'b0011 : 4'b1111) << off;
  endfunction
  // Stores replicate the datum across all lanes; byte enables pick the live one
  function automatic logic [XLEN-1:0] wd_of(input logic [1:0] sz, input logic [XLEN-1:0] w);
    return sz == SZ_B ? {4{w[7:0]}} : sz == SZ_H ? {2{w[15:0]}} : w;
  endfunction
  // f3[2] set means unsigned (BU/HU)
  function automatic logic [XLEN-1:0] ld_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [XLEN-1:0] r);
    logic [XLEN-1:0] s;
    s = r >> {off, 3'b000};
    return f3[1:0] == SZ_B ? {{(XLEN-8){s[7] & ~f3[2]}}, s[7:0]} :
           f3[1:0] == SZ_H ? {{(XLEN-16){s[15] & ~f3[2]}}, s[15:0]} : s;
  endfunction
endpackage

// File: rtl/membuf_fifo.sv
// membuf_fifo: synchronous FIFO holding queued memory requests
module membuf_fifo #(
  parameter int W = 73,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(D):0]   count
);
  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          wr, rd;
  // A push into a full queue is only accepted when the head leaves in the same cycle
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign full  = cnt_q == CW'(D);
  assign empty = cnt_q == '0;
  assign dout  = mem_q[rp_q];
  assign count = cnt_q;
  // Storage array, no reset needed since pointers gate visibility
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= din;
  end
  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(wr);
      rp_q  <= rp_q + AW'(rd);
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: rtl/membuf.sv
// membuf: in-order load/store request queue driving the data-memory bus with load writeback
module membuf
  import membuf_pkg::*;
#(
  parameter int MEMB_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_vld,
  input  logic [MEMB_PARA-1:0] mem_para,
  input  logic [XLEN-1:0]      mem_addr,
  input  logic [XLEN-1:0]      mem_wdata,
  output logic                 membuf_full,
  output logic                 membuf_idle,
  output logic                 mem_err,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [3:0]           dmem_be,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic [4:0]           lw_sel,
  output logic [XLEN-1:0]      lw_data
);
  localparam int CW = $clog2(MEMB_DEPTH) + 1;
  localparam logic [CW-1:0] DEP  = CW'(MEMB_DEPTH);
  localparam logic [CW-1:0] DEP1 = CW'(MEMB_DEPTH - 1);
  req_t            head;
  logic            pop, empty, fifo_full, full_d, full_q, ok;
  logic [CW-1:0]   count;
  state_t          state_q;
  logic            err_q, req_q, we_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] addr_q, wdata_q, lw_data_q;
  logic [4:0]      rd_q, lw_sel_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  membuf_fifo #(.W($bits(req_t)), .D(MEMB_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (mem_vld),
    .pop   (pop),
    .din   ({mem_para, mem_addr, mem_wdata}),
    .dout  (head),
    .full  (fifo_full),
    .empty (empty),
    .count (count)
  );
  assign ok     = legal(head.st, head.f3, head.addr[1:0]);
  // Bad requests leave from IDLE without touching the bus; good ones leave on grant
  assign pop    = (state_q == S_IDLE && !empty && !ok) || (state_q == S_REQ && dmem_gnt);
  assign full_d = (count == DEP) || (count == DEP1 && mem_vld && !pop);
  assign membuf_full = full_q;
  assign membuf_idle = empty && state_q == S_IDLE;
  assign mem_err     = err_q;
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_be     = be_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign lw_sel      = lw_sel_q;
  assign lw_data     = lw_data_q;
  // Registered back-pressure to the scheduler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= 1'b0;
    else     full_q <= full_d;
  end
  // Issue FSM: register head onto the bus, hold until grant, then await load data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      err_q     <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      lw_sel_q  <= '0;
      lw_data_q <= '0;
    end else begin
      err_q    <= 1'b0;
      lw_sel_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (!empty && !ok) err_q <= 1'b1;
          if (!empty && ok) begin
            req_q   <= 1'b1;
            we_q    <= head.st;
            be_q    <= be_of(head.f3[1:0], head.addr[1:0]);
            addr_q  <= {head.addr[XLEN-1:2], 2'b00};
            wdata_q <= wd_of(head.f3[1:0], head.wdata);
            rd_q    <= head.rd;
            f3_q    <= head.f3;
            off_q   <= head.addr[1:0];
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            req_q   <= 1'b0;
            state_q <= we_q ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            lw_sel_q  <= rd_q;
            lw_data_q <= ld_ext(f3_q, off_q, dmem_rdata);
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_membuf.sv
// tb_membuf: scoreboard bench for membuf with a simple bus responder
module tb_membuf;
  logic        clk = 1'b0, rst;
  logic        mem_vld;
  logic [8:0]  mem_para;
  logic [31:0] mem_addr, mem_wdata;
  logic        membuf_full, membuf_idle, mem_err;
  logic        dmem_req, dmem_we, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [4:0]  lw_sel;
  logic [31:0] lw_data;
  logic        gnt_en;
  int          lat, ld_cnt = 0;
  logic [31:0] rdata_next;
  int          checks = 0, failures = 0;

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  be;
    logic        we;
  } ev_t;
  ev_t exp_q[$];

  membuf #(.MEMB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .mem_vld(mem_vld), .mem_para(mem_para), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .membuf_full(membuf_full), .membuf_idle(membuf_idle),
    .mem_err(mem_err), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .lw_sel(lw_sel), .lw_data(lw_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic take_ev(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] be, input logic we);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_ev got k=%0d a=%h b=%h be=%b we=%b exp none", k, a, b, be, we);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.a !== a || e.b !== b || e.be !== be || e.we !== we) begin
        failures++;
        $display("FAIL ev got k=%0d a=%h b=%h be=%b we=%b exp k=%0d a=%h b=%h be=%b we=%b",
                 k, a, b, be, we, e.k, e.a, e.b, e.be, e.we);
      end
    end
  endtask

  // Responder: grant in the request cycle, return load data lat cycles after grant
  always @(negedge clk) begin
    dmem_rvalid = 1'b0;
    if (ld_cnt > 0) begin
      ld_cnt--;
      if (ld_cnt == 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata_next;
      end
    end
    dmem_gnt = dmem_req && gnt_en;
    if (dmem_gnt && !dmem_we) ld_cnt = lat;
  end

  // Monitor: every bus acceptance, writeback and error pulse consumes one expected event
  always @(negedge clk) begin
    if (dmem_req && gnt_en) take_ev(0, dmem_addr, dmem_wdata, dmem_be, dmem_we);
    if (lw_sel != 5'd0)     take_ev(1, {27'b0, lw_sel}, lw_data, 4'b0, 1'b0);
    if (mem_err)            take_ev(2, '0, '0, 4'b0, 1'b0);
  end

  function automatic ev_t mk(input int k, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] be, input logic we);
    ev_t e;
    e.k = k; e.a = a; e.b = b; e.be = be; e.we = we;
    return e;
  endfunction

  task automatic eb(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] w);
    exp_q.push_back(mk(0, a, w, be, we));
  endtask
  task automatic ew(input logic [4:0] sel, input logic [31:0] d);
    exp_q.push_back(mk(1, {27'b0, sel}, d, 4'b0, 1'b0));
  endtask
  task automatic ee();
    exp_q.push_back(mk(2, '0, '0, 4'b0, 1'b0));
  endtask

  task automatic req(input logic [4:0] rd, input logic [2:0] f3, input logic st,
                     input logic [31:0] a, input logic [31:0] w);
    mem_vld = 1'b1; mem_para = {rd, f3, st}; mem_addr = a; mem_wdata = w;
    @(posedge clk); #1;
    mem_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(membuf_idle && exp_q.size() == 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timeout idle=%b pending=%0d exp idle=1 pending=0", membuf_idle, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; mem_vld = 1'b0; mem_para = '0; mem_addr = '0; mem_wdata = '0;
    gnt_en = 1'b1; lat = 2; rdata_next = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_full", {31'b0, membuf_full}, 0);
    chk("rst_idle", {31'b0, membuf_idle}, 1);
    chk("rst_err", {31'b0, mem_err}, 0);
    chk("rst_req", {31'b0, dmem_req}, 0);
    chk("rst_we", {31'b0, dmem_we}, 0);
    chk("rst_be", {28'b0, dmem_be}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_lw_sel", {27'b0, lw_sel}, 0);
    chk("rst_lw_data", lw_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    eb(1'b1, 4'b1111, 32'h100, 32'hDEADBEEF);
    req(5'd0, 3'd2, 1'b1, 32'h100, 32'hDEADBEEF);
    chk("sw_c1_req", {31'b0, dmem_req}, 0);
    chk("sw_c1_idle", {31'b0, membuf_idle}, 0);
    @(posedge clk); #1 chk("sw_c2_req", {31'b0, dmem_req}, 1);
    @(posedge clk); #1 chk("sw_c3_idle", {31'b0, membuf_idle}, 1);
    chk("sw_c3_req", {31'b0, dmem_req}, 0);
    rdata_next = 32'h80FFFFFF;
    eb(1'b0, 4'b1000, 32'h200, 32'h0); ew(5'd5, 32'hFFFFFF80);
    req(5'd5, 3'd0, 1'b0, 32'h203, 32'h0); wait_idle();
    eb(1'b0, 4'b1000, 32'h200, 32'h0); ew(5'd6, 32'h00000080);
    req(5'd6, 3'd4, 1'b0, 32'h203, 32'h0); wait_idle();
    eb(1'b1, 4'b1100, 32'h100, 32'h12341234);
    req(5'd0, 3'd1, 1'b1, 32'h102, 32'h00001234); wait_idle();
    ee();
    req(5'd7, 3'd1, 1'b0, 32'h101, 32'h0); wait_idle();
    eb(1'b1, 4'b0010, 32'h100, 32'hABABABAB);
    req(5'd0, 3'd0, 1'b1, 32'h101, 32'h000000AB); wait_idle();
    rdata_next = 32'h80017FFF;
    eb(1'b0, 4'b1100, 32'h104, 32'h0); ew(5'd8, 32'hFFFF8001);
    req(5'd8, 3'd1, 1'b0, 32'h106, 32'h0); wait_idle();
    eb(1'b0, 4'b0011, 32'h104, 32'h0); ew(5'd9, 32'h00007FFF);
    req(5'd9, 3'd5, 1'b0, 32'h104, 32'h0); wait_idle();
    rdata_next = 32'h12345678;
    eb(1'b0, 4'b1111, 32'h108, 32'h0); ew(5'd10, 32'h12345678);
    req(5'd10, 3'd2, 1'b0, 32'h108, 32'h0); wait_idle();
    ee();
    req(5'd12, 3'd3, 1'b0, 32'h100, 32'h0); wait_idle();
    ee();
    req(5'd0, 3'd4, 1'b1, 32'h100, 32'h0); wait_idle();
    ee();
    req(5'd0, 3'd2, 1'b1, 32'h102, 32'h55555555); wait_idle();
    rdata_next = 32'hCAFEF00D;
    eb(1'b0, 4'b1111, 32'h10C, 32'h0);
    req(5'd0, 3'd2, 1'b0, 32'h10C, 32'h0); wait_idle();
    // Fill with grants held off, then release and check ordering and full release
    gnt_en = 1'b0;
    for (int i = 0; i < 4; i++) eb(1'b1, 4'b1111, 32'h10 + 32'(i * 4), 32'hA0 + 32'(i));
    req(5'd0, 3'd2, 1'b1, 32'h10, 32'hA0);
    req(5'd0, 3'd2, 1'b1, 32'h14, 32'hA1);
    req(5'd0, 3'd2, 1'b1, 32'h18, 32'hA2);
    chk("full_after3", {31'b0, membuf_full}, 0);
    req(5'd0, 3'd2, 1'b1, 32'h1C, 32'hA3);
    chk("full_after4", {31'b0, membuf_full}, 1);
    gnt_en = 1'b1;
    for (int i = 0; i < 10 && membuf_full; i++) begin @(posedge clk); #1; end
    chk("full_drop", {31'b0, membuf_full}, 0);
    wait_idle();
    // Push into a full queue in the same cycle the head is granted
    gnt_en = 1'b0;
    for (int i = 0; i < 5; i++) eb(1'b1, 4'b1111, 32'h40 + 32'(i * 4), 32'hB0 + 32'(i));
    req(5'd0, 3'd2, 1'b1, 32'h40, 32'hB0);
    req(5'd0, 3'd2, 1'b1, 32'h44, 32'hB1);
    req(5'd0, 3'd2, 1'b1, 32'h48, 32'hB2);
    req(5'd0, 3'd2, 1'b1, 32'h4C, 32'hB3);
    chk("full_before_pp", {31'b0, membuf_full}, 1);
    gnt_en = 1'b1;
    req(5'd0, 3'd2, 1'b1, 32'h50, 32'hB4);
    @(posedge clk); #1 chk("full_kept_pp", {31'b0, membuf_full}, 1);
    wait_idle();
    // Reset while a load awaits data; the late rvalid must be ignored
    lat = 4; rdata_next = 32'h11111111;
    eb(1'b0, 4'b1111, 32'h200, 32'h0);
    req(5'd11, 3'd2, 1'b0, 32'h200, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rw_req", {31'b0, dmem_req}, 0);
    chk("rw_be", {28'b0, dmem_be}, 0);
    chk("rw_addr", dmem_addr, 0);
    repeat (6) begin @(posedge clk); #1; end
    chk("rw_lw_sel", {27'b0, lw_sel}, 0);
    chk("rw_lw_data", lw_data, 0);
    chk("rw_idle", {31'b0, membuf_idle}, 1);
    chk("rw_err", {31'b0, mem_err}, 0);
    repeat (3) @(posedge clk);
    #1 chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
